// File: rtl/therm_n1_load_store.sv
// Load/store stage: computes the effective address, runs one doubleword access on the
// simple memory bus and returns the extended load result or a fault code.
module therm_n1_load_store #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_neg,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_base,
    input  logic [11:0] req_offset,
    input  logic [63:0] req_store_data,
    input  logic [4:0]  req_rd,
    output logic [63:0] mem_address,
    output logic        mem_chip_enable,
    output logic        mem_write_enable,
    output logic [7:0]  mem_byte_enable,
    output logic [63:0] mem_data_store,
    input  logic [63:0] mem_data_load,
    input  logic        mem_ready,
    output logic        resp_valid,
    output logic [1:0]  resp_fault,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       funct3_q, funct3_nx;
    logic             store_q, store_nx;
    logic [2:0]       lane_q, lane_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;

    logic [63:0] mem_address_nx;
    logic        mem_chip_enable_nx;
    logic        mem_write_enable_nx;
    logic [7:0]  mem_byte_enable_nx;
    logic [63:0] mem_data_store_nx;
    logic        resp_valid_nx;
    logic [1:0]  resp_fault_nx;
    logic        wb_valid_nx;
    logic [4:0]  wb_rd_nx;
    logic [63:0] wb_data_nx;

    logic signed [63:0] offset_sext;
    logic [63:0]        ea;
    logic               req_illegal;
    logic               req_misaligned;

    // Lane mask for an access of 2**size_log bytes starting at byte lane 'lane'.
    function automatic logic [7:0] lane_mask(input logic [1:0] size_log, input logic [2:0] lane);
        logic [7:0] m;
        case (size_log)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << lane;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size_log, input logic [2:0] lo);
        logic r;
        case (size_log)
            2'd0:    r = 1'b0;
            2'd1:    r = lo[0];
            2'd2:    r = |lo[1:0];
            default: r = |lo[2:0];
        endcase
        return r;
    endfunction

    // Shift the addressed bytes down to bit 0, then sign- or zero-extend to 64 bits.
    function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [2:0] lane,
                                                input logic [2:0] f3);
        logic [63:0] d;
        logic [63:0] r;
        d = raw >> {lane, 3'b000};
        case (f3)
            3'b000:  r = {{56{d[7]}}, d[7:0]};
            3'b001:  r = {{48{d[15]}}, d[15:0]};
            3'b010:  r = {{32{d[31]}}, d[31:0]};
            3'b100:  r = {56'd0, d[7:0]};
            3'b101:  r = {48'd0, d[15:0]};
            3'b110:  r = {32'd0, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign offset_sext    = {{52{req_offset[11]}}, req_offset};
    assign ea             = req_base + offset_sext;
    assign req_illegal    = req_store ? req_funct3[2] : (req_funct3 == 3'b111);
    assign req_misaligned = is_misaligned(req_funct3[1:0], ea[2:0]);
    assign req_ready      = (state == IDLE);

    always_comb begin
        state_nx            = state;
        funct3_nx           = funct3_q;
        store_nx            = store_q;
        lane_nx             = lane_q;
        cnt_nx              = cnt_q;
        mem_address_nx      = mem_address;
        mem_chip_enable_nx  = mem_chip_enable;
        mem_write_enable_nx = mem_write_enable;
        mem_byte_enable_nx  = mem_byte_enable;
        mem_data_store_nx   = mem_data_store;
        resp_valid_nx       = 1'b0;
        resp_fault_nx       = resp_fault;
        wb_valid_nx         = 1'b0;
        wb_rd_nx            = wb_rd;
        wb_data_nx          = wb_data;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    funct3_nx = req_funct3;
                    store_nx  = req_store;
                    lane_nx   = ea[2:0];
                    wb_rd_nx  = req_rd;
                    cnt_nx    = '0;
                    // Illegal width takes priority over alignment; either skips the bus.
                    if (req_illegal) begin
                        state_nx      = RESPOND;
                        resp_valid_nx = 1'b1;
                        resp_fault_nx = FAULT_ILLEGAL;
                    end else if (req_misaligned) begin
                        state_nx      = RESPOND;
                        resp_valid_nx = 1'b1;
                        resp_fault_nx = FAULT_MISALIGN;
                    end else begin
                        state_nx            = ACCESS;
                        resp_fault_nx       = FAULT_NONE;
                        mem_chip_enable_nx  = 1'b1;
                        mem_write_enable_nx = req_store;
                        mem_address_nx      = {ea[63:3], 3'b000};
                        mem_byte_enable_nx  = req_store ? lane_mask(req_funct3[1:0], ea[2:0]) : 8'hFF;
                        mem_data_store_nx   = req_store_data << {ea[2:0], 3'b000};
                    end
                end
            end
            ACCESS: begin
                // A completion arriving on the final timeout cycle still counts as a completion.
                if (mem_ready) begin
                    state_nx            = RESPOND;
                    mem_chip_enable_nx  = 1'b0;
                    mem_write_enable_nx = 1'b0;
                    resp_valid_nx       = 1'b1;
                    resp_fault_nx       = FAULT_NONE;
                    wb_valid_nx         = !store_q && (wb_rd != 5'd0);
                    if (!store_q) begin
                        wb_data_nx = load_extend(mem_data_load, lane_q, funct3_q);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_nx            = RESPOND;
                    mem_chip_enable_nx  = 1'b0;
                    mem_write_enable_nx = 1'b0;
                    resp_valid_nx       = 1'b1;
                    resp_fault_nx       = FAULT_TIMEOUT;
                end else begin
                    cnt_nx = cnt_q + 1'b1;
                end
            end
            RESPOND: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_neg) begin
        if (!reset_neg) begin
            state            <= IDLE;
            funct3_q         <= 3'd0;
            store_q          <= 1'b0;
            lane_q           <= 3'd0;
            cnt_q            <= '0;
            mem_address      <= 64'd0;
            mem_chip_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_byte_enable  <= 8'd0;
            mem_data_store   <= 64'd0;
            resp_valid       <= 1'b0;
            resp_fault       <= 2'd0;
            wb_valid         <= 1'b0;
            wb_rd            <= 5'd0;
            wb_data          <= 64'd0;
        end else begin
            state            <= state_nx;
            funct3_q         <= funct3_nx;
            store_q          <= store_nx;
            lane_q           <= lane_nx;
            cnt_q            <= cnt_nx;
            mem_address      <= mem_address_nx;
            mem_chip_enable  <= mem_chip_enable_nx;
            mem_write_enable <= mem_write_enable_nx;
            mem_byte_enable  <= mem_byte_enable_nx;
            mem_data_store   <= mem_data_store_nx;
            resp_valid       <= resp_valid_nx;
            resp_fault       <= resp_fault_nx;
            wb_valid         <= wb_valid_nx;
            wb_rd            <= wb_rd_nx;
            wb_data          <= wb_data_nx;
        end
    end

endmodule
